// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the ALU control / multiply sequencer.
//   GOUT_*  : 3-bit ALU operation codes driven on gout
//   FN_*    : funct encodings of the multiply-unit instructions
//   RES_*   : writeback source select codes
//   state_t : sequencer states
package alu_seq_pkg;

  localparam logic [2:0] GOUT_AND = 3'b000;
  localparam logic [2:0] GOUT_OR  = 3'b001;
  localparam logic [2:0] GOUT_ADD = 3'b010;
  localparam logic [2:0] GOUT_SUB = 3'b110;
  localparam logic [2:0] GOUT_SLT = 3'b111;
  localparam logic [2:0] GOUT_NOR = 3'b011;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_HI  = 2'b01;
  localparam logic [1:0] RES_LO  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl_mdu.sv
// mdu_shift_add: iterative shift-add multiplier, one partial product per cycle.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands, clear accumulator, cnt = WIDTH-1
//   run        : perform one iteration this cycle
//   signed_op  : operands are two's complement (mult) rather than unsigned
//   a, b       : operands, sampled on start
//   last       : cnt is zero, i.e. this iteration is the final one
//   product    : sign-corrected result of the current (final) iteration
module mdu_shift_add
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 run,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Magnitudes stay W-bit unsigned so that -2^(W-1) maps to 2^(W-1) intact.
  always_comb begin
    mag_a = (signed_op && a[WIDTH-1]) ? -a : a;
    mag_b = (signed_op && b[WIDTH-1]) ? -b : b;
  end

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nxt = {sum, acc[WIDTH-1:1]};
    product = neg ? -acc_nxt : acc_nxt;
    last    = (cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else if (start) begin
      mcand  <= mag_a;
      mplier <= mag_b;
      acc    <= '0;
      cnt    <= CNT_W'(WIDTH - 1);
      neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (run) begin
      acc    <= acc_nxt;
      mplier <= mplier >> 1;
      if (!last) cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: ALU operation decoder plus mult/multu/mfhi/mflo sequencing.
//   clk, rst_n : clock, async active-low reset
//   aluop      : [3] ori, [2] andi, [1] beq, [0] R-type; zero = addi
//   funct      : instruction funct field
//   valid      : instruction presented this cycle
//   a, b       : rs / rt operands
//   gout       : ALU operation code
//   res_sel    : writeback source (ALU / HI / LO)
//   hilo_out   : HI or LO per res_sel, else 0
//   stall      : hold PC/IF this cycle
//   busy       : multiply in progress
//   mdu_done   : one-cycle pulse on the HI/LO write cycle
//
// state | meaning
// IDLE  | no multiply running; decode mult/multu to start one
// RUN   | one shift-add iteration per cycle; cnt==0 writes HI/LO
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       aluop,
  input  logic [5:0]       funct,
  input  logic             valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       gout,
  output logic [1:0]       res_sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic             stall,
  output logic             busy,
  output logic             mdu_done
);

  state_t             state;
  state_t             state_nxt;
  logic               r_valid;
  logic               is_mul;
  logic               is_mfhi;
  logic               is_mflo;
  logic               start;
  logic               last;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [3:0]         f;

  assign f       = funct[3:0];
  assign r_valid = aluop[0] & valid;
  assign is_mul  = r_valid & ((funct == FN_MULT) | (funct == FN_MULTU));
  assign is_mfhi = r_valid & (funct == FN_MFHI);
  assign is_mflo = r_valid & (funct == FN_MFLO);

  // Later rules override earlier ones, so the R-type block sits last.
  always_comb begin
    gout = GOUT_ADD;
    if (aluop[3]) gout = GOUT_OR;
    if (aluop[2]) gout = GOUT_AND;
    if (aluop[1]) gout = GOUT_SUB;
    if (aluop[0]) begin
      if (f == 4'b0000)                 gout = GOUT_ADD;
      if (f[1] & f[3])                  gout = GOUT_SLT;
      if (f[1] & ~f[3])                 gout = GOUT_SUB;
      if (f[2] & f[0])                  gout = GOUT_OR;
      if (f[2] & ~f[0])                 gout = GOUT_AND;
      if (~f[3] & f[2] & f[1] & f[0])   gout = GOUT_NOR;
    end
  end

  always_comb begin
    res_sel = RES_ALU;
    if (is_mfhi) res_sel = RES_HI;
    if (is_mflo) res_sel = RES_LO;
  end

  always_comb begin
    hilo_out = '0;
    if (res_sel == RES_HI) hilo_out = hi;
    if (res_sel == RES_LO) hilo_out = lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (is_mul) state_nxt = RUN;
      RUN:  if (last)   state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // The cnt==0 cycle is left unstalled so the multiply retires with the
  // HI/LO write; an mfhi/mflo arriving then waits one more cycle.
  always_comb begin
    busy     = (state == RUN);
    start    = (state == IDLE) & is_mul;
    mdu_done = busy & last;
    stall    = start | (busy & ~last) | (busy & (is_mfhi | is_mflo));
  end

  mdu_shift_add #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .run       (busy),
    .signed_op (funct == FN_MULT),
    .a         (a),
    .b         (b),
    .last      (last),
    .product   (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (mdu_done) begin
      hi <= product[2*WIDTH-1:WIDTH];
      lo <= product[WIDTH-1:0];
    end
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Parametrised ALU control with an attached iterative multiply sequencer. It decodes `aluop`/`funct` into the 3-bit ALU operation code `gout`, using the same encoding and override priority as the current decoder. It also adds `mult`/`multu`/`mfhi`/`mflo`, run over WIDTH cycles on a shift-add engine. It sits between the main control unit and the ALU/writeback mux, and drives a `stall` that holds the PC during multiplies.

## Interface
- `WIDTH`, 32: operand width; HI/LO are WIDTH bits each; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH): iteration counter width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `aluop`  in  4  [3]=ori, [2]=andi, [1]=beq, [0]=R-type; all zero = addi.
- `funct`  in  6  instruction funct field.
- `valid`  in  1  instruction presented this cycle.
- `a`, `b`  in  WIDTH  rs/rt operands.
- `gout`  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt, 011 nor.
- `res_sel`  out  2  writeback source: 00 ALU, 01 HI, 10 LO.
- `hilo_out`  out  WIDTH  HI when `res_sel`=01, LO when 10, else 0.
- `stall`  out  1  hold PC/IF this cycle.
- `busy`  out  1  multiply in progress (state RUN).
- `mdu_done`  out  1  one-cycle pulse on the HI/LO write cycle.

## Operation
- `gout` decode is combinational. Rules are applied in this order; a later match overrides an earlier one:
  - no aluop bit set → 010.
  - [3] → 001.
  - [2] → 000.
  - [1] → 110.
  - [0] with f=funct[3:0]:
    - f=0000 → 010.
    - f1&f3 → 111.
    - f1&~f3 → 110.
    - f2&f0 → 001.
    - f2&~f0 → 000.
    - ~f3&f2&f1&f0 → 011.
- MDU ops apply only when `aluop[0]`=1 and `valid`=1. On these, `gout` is don't-care (the ALU result is unused).
  - 011000 `mult`, signed.
  - 011001 `multu`, unsigned.
  - 010000 `mfhi`: `res_sel`=01.
  - 010010 `mflo`: `res_sel`=10.
- `res_sel`=00 for every other op, and whenever `valid`=0.
- FSM states: IDLE, RUN.
  - IDLE → RUN on `valid` & mult/multu.
    - Latch |a| and |b| into the multiplicand/multiplier registers; `multu` takes them raw.
    - Latch `neg` = a[W-1]^b[W-1] for `mult`, 0 for `multu`.
    - Clear the 2W accumulator; cnt=WIDTH-1.
  - RUN, each cycle:
    - If multiplier[0], accumulator upper half += multiplicand (W+1-bit sum).
    - Then shift {carry,acc,multiplier} right by 1; cnt−1.
  - RUN with cnt=0: perform the final iteration, then write {HI,LO} = `neg` ? −product : product, modulo 2^(2W). Assert `mdu_done`; → IDLE.
- `valid` and the operands are ignored while in RUN.
- HI/LO hold their value until the next multiply completes.
- `mfhi`/`mflo` while `busy`: `stall`=1 until the IDLE cycle after completion, so they see the new HI/LO.
- Signed edge case: −2^(W−1)·−2^(W−1) must give +2^(2W−2). Magnitudes are therefore W-bit unsigned, never sign-truncated.

## Timing
- Reset: state=IDLE, cnt=0, HI=LO=0, accumulator=0, `neg`=0.
  - Outputs after reset: `busy`=0, `mdu_done`=0, `stall`=0.
  - `gout`/`res_sel`/`hilo_out` follow their combinational rules from the inputs.
- `stall` = (IDLE & `valid` & mult/multu) | (RUN & cnt≠0) | (RUN & `valid` & mfhi/mflo).
  - The cnt=0 cycle is unstalled, so the multiply instruction retires on the same edge as the HI/LO write.
- Multiply latency: accept cycle + WIDTH RUN cycles.
  - `stall` is high for WIDTH cycles.
  - HI/LO are valid from the edge ending RUN cnt=0.
  - A back-to-back multiply is accepted in the very next IDLE cycle.
- `rst_n` asserted mid-RUN aborts the multiply; HI/LO go to 0, not the partial result.

## Structure
- `alu_seq_pkg` holds:
  - the GOUT_* 3-bit codes;
  - FN_MULT / FN_MULTU / FN_MFHI / FN_MFLO;
  - RES_ALU / RES_HI / RES_LO;
  - the state enum {IDLE, RUN}.
- Sub-module `mdu_shift_add` (WIDTH-parametrised):
  - owns the multiplicand, multiplier, accumulator, cnt, `neg` and the final negate;
  - interface: `start`, `signed_op`, `a`, `b`, `last`, `product`.
- The top level keeps the decoder, FSM, stall logic and HI/LO registers.

## Test plan
- `aluop` sweep, with `funct`=100100 (f=0100) at `aluop`=0001: 0000→010, 1000→001, 0100→000, 0010→110, 0001→000. Then f=0000→010, 1010→111, 0010→110, 0101→001, 0111→011.
- WIDTH=8, `multu` a=0xFF, b=0xFF:
  - `stall` high exactly 8 cycles;
  - `mdu_done` pulses once;
  - HI=0xFE, LO=0x01.
- WIDTH=8, `mult` cases:
  - a=0x80, b=0x80 → HI=0x40, LO=0x00.
  - a=0xFD (−3), b=0x05 → HI=0xFF, LO=0xF1.
- `mflo` issued in the cycle after a `mult` retires → `res_sel`=10, `hilo_out`=new LO, `stall`=0.
  - `mfhi` presented during RUN → `stall` stays high until IDLE, then `hilo_out`=new HI.
- `rst_n` pulsed low at RUN cnt=3 → immediately `busy`=0, `stall`=0, HI=LO=0.
  - After reset release, a new `multu` 3×4 gives LO=12.
- Two consecutive `multu` (2×3, then 5×7) → accepted on the cycle right after the first retires; LO=6, then LO=35.
